morse_tx_timed: RTL and testbench

- Parametrised successor of the Morse transmit FSM. It accepts one Morse symbol per valid/ready handshake: dot, dash, character space or word space.
- Each symbol is played out on a keyed line (key_out) with configurable unit length and configurable per-symbol unit counts.
- A 2-bit status code (parallel_out) keeps the existing encoding. A done pulse marks the end of each symbol.
- Sits between the character-to-symbol encoder upstream and the keying/LED driver downstream.

---
 rtl/morse_pkg.sv | 30 +++
 rtl/morse_unit_tick.sv | 30 +++
 rtl/morse_tx_timed.sv | 173 +++++++++++++++++
 tb/tb_morse_tx_timed.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared encodings for the Morse transmit/receive blocks.
//   - symbol codes on the upstream handshake (sym_code)
//   - status codes driven on parallel_out
//   - transmit FSM state encoding
package morse_pkg;

  // upstream symbol codes
  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_CHAR = 2'b10;
  localparam logic [1:0] SYM_WORD = 2'b11;

  // parallel_out status codes
  localparam logic [1:0] OUT_IDLE  = 2'b00;
  localparam logic [1:0] OUT_DOT   = 2'b01;
  localparam logic [1:0] OUT_DASH  = 2'b10;
  localparam logic [1:0] OUT_SPACE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MARK  = 2'b01,
    GAP   = 2'b10,
    SPACE = 2'b11
  } state_t;

  function automatic logic is_mark(input logic [1:0] code);
    return (code == SYM_DOT) || (code == SYM_DASH);
  endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// morse_unit_tick: unit prescaler shared by the Morse transmit and receive
// sides. Counts 0..period-1 and flags the last cycle of each unit.
//   clk       in   clock, posedge
//   rst       in   synchronous active-low reset
//   clear     in   restart the unit (count back to 0 next cycle)
//   period    in   cycles per unit; 0 behaves as 1
//   unit_tick out  high on the last cycle of a unit
module morse_unit_tick #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             unit_tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  assign last      = (period == '0) ? '0 : period - CNT_W'(1);
  assign unit_tick = (cnt == last);

  always_ff @(posedge clk) begin
    if (!rst)                    cnt <= '0;
    else if (clear || unit_tick) cnt <= '0;
    else                         cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/morse_tx_timed.sv
// morse_tx_timed: timed Morse symbol transmitter.
// Accepts one symbol (dot/dash/char space/word space) per valid/ready
// handshake and plays it out on key_out, unit length UNIT_CYCLES.
// A dot/dash is followed by a GAP_UNITS key-off gap; spaces are key-off only.
//   clk          in   clock, posedge
//   rst          in   synchronous active-low reset
//   sym_valid    in   symbol valid
//   sym_code     in   00 dot, 01 dash, 10 char space, 11 word space
//   unit_cycles  in   (MORSE_TX_RUNTIME_UNIT_EN only) unit length, latched on accept
//   sym_ready    out  high in IDLE
//   key_out      out  carrier on
//   parallel_out out  00 idle/gap, 01 dot, 10 dash, 11 space
//   sym_done     out  one-cycle pulse on the first IDLE cycle after a symbol
//   busy         out  state != IDLE
// Optional: define MORSE_TX_RUNTIME_UNIT_EN for a runtime unit length port.
module morse_tx_timed
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = 16,
  parameter int DOT_UNITS   = 1,
  parameter int DASH_UNITS  = 3,
  parameter int GAP_UNITS   = 1,
  parameter int CHAR_UNITS  = 3,
  parameter int WORD_UNITS  = 7,
  parameter int UCNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [1:0]       sym_code,
`ifdef MORSE_TX_RUNTIME_UNIT_EN
  input  logic [CNT_W-1:0] unit_cycles,
`endif
  output logic             sym_ready,
  output logic             key_out,
  output logic [1:0]       parallel_out,
  output logic             sym_done,
  output logic             busy
);

  // elaboration-time parameter checks
  if (UNIT_CYCLES < 1 || DOT_UNITS < 1 || DASH_UNITS < 1 || GAP_UNITS < 1 ||
      CHAR_UNITS < 1 || WORD_UNITS < 1) begin : g_bad_zero
    $error("morse_tx_timed: UNIT_CYCLES and every *_UNITS must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 30 || UNIT_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt
    $error("morse_tx_timed: 2**CNT_W must exceed UNIT_CYCLES");
  end
  if (UCNT_W < 1 || UCNT_W > 30 ||
      DOT_UNITS  >= (1 << UCNT_W) || DASH_UNITS >= (1 << UCNT_W) ||
      GAP_UNITS  >= (1 << UCNT_W) || CHAR_UNITS >= (1 << UCNT_W) ||
      WORD_UNITS >= (1 << UCNT_W)) begin : g_bad_ucnt
    $error("morse_tx_timed: UCNT_W too narrow for the *_UNITS values");
  end

  state_t            state, state_nx;
  logic [1:0]        code_q, code_nx;
  logic [UCNT_W-1:0] ucnt, ucnt_nx;
  logic              key_nx, done_nx;
  logic [1:0]        pout_nx;
  logic              accept;
  logic              unit_tick;
  logic              last_unit;
  logic              tick_clear;
  logic [CNT_W-1:0]  period;

  assign sym_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = sym_valid && sym_ready;
  assign last_unit = unit_tick && (ucnt == UCNT_W'(1));

  // Restarting the prescaler on every state change keeps each phase an
  // exact multiple of the unit, aligned to the accept edge.
  assign tick_clear = accept || (state_nx != state);

`ifdef MORSE_TX_RUNTIME_UNIT_EN
  logic [CNT_W-1:0] period_q;

  always_ff @(posedge clk) begin
    if (!rst)        period_q <= CNT_W'(UNIT_CYCLES);
    else if (accept) period_q <= (unit_cycles == '0) ? CNT_W'(1) : unit_cycles;
  end

  assign period = period_q;
`else
  assign period = CNT_W'(UNIT_CYCLES);
`endif

  morse_unit_tick #(
    .CNT_W (CNT_W)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clear     (tick_clear),
    .period    (period),
    .unit_tick (unit_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      code_q       <= SYM_DOT;
      ucnt         <= '0;
      key_out      <= 1'b0;
      parallel_out <= OUT_IDLE;
      sym_done     <= 1'b0;
    end else begin
      state        <= state_nx;
      code_q       <= code_nx;
      ucnt         <= ucnt_nx;
      key_out      <= key_nx;
      parallel_out <= pout_nx;
      sym_done     <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    ucnt_nx  = ucnt;
    done_nx  = 1'b0;
    key_nx   = 1'b0;
    pout_nx  = OUT_IDLE;

    case (state)
      IDLE: begin
        if (accept) begin
          code_nx = sym_code;
          if (is_mark(sym_code)) begin
            state_nx = MARK;
            ucnt_nx  = (sym_code == SYM_DASH) ? UCNT_W'(DASH_UNITS) : UCNT_W'(DOT_UNITS);
          end else begin
            state_nx = SPACE;
            ucnt_nx  = (sym_code == SYM_WORD) ? UCNT_W'(WORD_UNITS) : UCNT_W'(CHAR_UNITS);
          end
        end
      end
      MARK: begin
        if (last_unit) begin
          state_nx = GAP;
          ucnt_nx  = UCNT_W'(GAP_UNITS);
        end else if (unit_tick) begin
          ucnt_nx = ucnt - UCNT_W'(1);
        end
      end
      GAP, SPACE: begin
        if (last_unit) begin
          state_nx = IDLE;
          ucnt_nx  = '0;
          done_nx  = 1'b1;
        end else if (unit_tick) begin
          ucnt_nx = ucnt - UCNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        ucnt_nx  = '0;
      end
    endcase

    // outputs are registered: decode them from the state being entered
    case (state_nx)
      MARK: begin
        key_nx  = 1'b1;
        pout_nx = (code_nx == SYM_DASH) ? OUT_DASH : OUT_DOT;
      end
      SPACE:   pout_nx = OUT_SPACE;
      default: pout_nx = OUT_IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_tx_timed.sv
// Bench for morse_tx_timed. A queue model expands every accepted symbol into
// its expected per-cycle outputs; a negedge process compares the DUT against
// it each cycle, and directed tests pin the model with literal cycle counts.
module tb_morse_tx_timed;

  localparam int U = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_code = 2'b00;
  logic [15:0] unit_cycles = 16'd4;
  logic        sym_ready, key_out, sym_done, busy;
  logic [1:0]  parallel_out;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  morse_tx_timed #(
    .UNIT_CYCLES (4), .CNT_W (16), .DOT_UNITS (1), .DASH_UNITS (3),
    .GAP_UNITS (1), .CHAR_UNITS (3), .WORD_UNITS (7), .UCNT_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sym_valid    (sym_valid),
    .sym_code     (sym_code),
`ifdef MORSE_TX_RUNTIME_UNIT_EN
    .unit_cycles  (unit_cycles),
`endif
    .sym_ready    (sym_ready),
    .key_out      (key_out),
    .parallel_out (parallel_out),
    .sym_done     (sym_done),
    .busy         (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic       key;
    logic [1:0] po;
    logic       done;
    logic       busy;
  } exp_t;

  function automatic exp_t mk(input logic k, input logic [1:0] p, input logic d, input logic b);
    exp_t e;
    e.key = k; e.po = p; e.done = d; e.busy = b;
    return e;
  endfunction

  exp_t q[$];
  exp_t cur = '0;

  // a symbol is N units of its mark/space pattern, one gap unit after a
  // mark, then a single idle cycle carrying the done pulse
  task automatic push_sym(input logic [1:0] c, input int u);
    if (c == 2'b00 || c == 2'b01) begin
      repeat ((c == 2'b00 ? 1 : 3) * u) q.push_back(mk(1'b1, c == 2'b00 ? 2'b01 : 2'b10, 1'b0, 1'b1));
      repeat (u) q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1));
    end else begin
      repeat ((c == 2'b10 ? 3 : 7) * u) q.push_back(mk(1'b0, 2'b11, 1'b0, 1'b1));
    end
    q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0));
  endtask

  function automatic int unit_now();
`ifdef MORSE_TX_RUNTIME_UNIT_EN
    return (unit_cycles == 16'd0) ? 1 : int'(unit_cycles);
`else
    return U;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst) q.delete();
    else if (sym_valid && !cur.busy) push_sym(sym_code, unit_now());
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cur = (q.size() > 0) ? q.pop_front() : mk(1'b0, 2'b00, 1'b0, 1'b0);
      chk("key_out",      int'(key_out),      int'(cur.key));
      chk("parallel_out", int'(parallel_out), int'(cur.po));
      chk("sym_done",     int'(sym_done),     int'(cur.done));
      chk("busy",         int'(busy),         int'(cur.busy));
      chk("sym_ready",    int'(sym_ready),    int'(!cur.busy));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [1:0] c);
    sym_valid = 1'b1;
    sym_code  = c;
    @(posedge clk);
    #1 sym_valid = 1'b0;
  endtask

  // Called just after the accept edge; cycle 1 is the first symbol cycle.
  task automatic measure(input bit jam, output int hi, output int gp, output int sp,
                         output int rdy, output int done_at, output int po1);
    hi = 0; gp = 0; sp = 0; rdy = 0; done_at = -1; po1 = -1;
    if (jam) begin sym_valid = 1'b1; sym_code = 2'($urandom_range(0, 3)); end
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) po1 = int'(parallel_out);
      if (sym_done) begin done_at = c; break; end
      if (key_out) hi++;
      else if (parallel_out == 2'b11) sp++;
      else if (busy) gp++;
      if (sym_ready) rdy++;
      if (jam) sym_code = 2'($urandom_range(0, 3));
    end
    sym_valid = 1'b0;
  endtask

  int hi, gp, sp, rdy, dn, po1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset key_out", int'(key_out), 0);
    chk("reset parallel_out", int'(parallel_out), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset sym_ready", int'(sym_ready), 1);
    chk("reset sym_done", int'(sym_done), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // dot: 4 high, 4 low, done at cycle 9
    send(2'b00);
    measure(1'b0, hi, gp, sp, rdy, dn, po1);
    chk("dot high", hi, 4);
    chk("dot gap", gp, 4);
    chk("dot code", po1, 1);
    chk("dot done cycle", dn, 9);
    chk("dot ready at done", int'(sym_ready), 1);

    // dash: 12 high, 4 low, done at 17
    send(2'b01);
    measure(1'b0, hi, gp, sp, rdy, dn, po1);
    chk("dash high", hi, 12);
    chk("dash gap", gp, 4);
    chk("dash code", po1, 2);
    chk("dash done cycle", dn, 17);

    // char space then word space accepted in the done cycle
    send(2'b10);
    measure(1'b0, hi, gp, sp, rdy, dn, po1);
    chk("char space len", sp, 12);
    chk("char done cycle", dn, 13);
    send(2'b11);
    measure(1'b0, hi, gp, sp, rdy, dn, po1);
    chk("word space len", sp, 28);
    chk("word key high", hi, 0);
    chk("word done cycle", dn, 29);

    // dash with sym_valid held and code churning: no extra accepts
    send(2'b01);
    measure(1'b1, hi, gp, sp, rdy, dn, po1);
    chk("jam dash high", hi, 12);
    chk("jam dash gap", gp, 4);
    chk("jam ready while busy", rdy, 0);
    chk("jam done cycle", dn, 17);
    repeat (3) @(negedge clk);

    // reset asserted during cycle 6 of a dash
    send(2'b01);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst key_out", int'(key_out), 0);
    chk("midrst parallel_out", int'(parallel_out), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst sym_ready", int'(sym_ready), 1);
    chk("midrst sym_done", int'(sym_done), 0);
    repeat (20) @(negedge clk);

`ifdef MORSE_TX_RUNTIME_UNIT_EN
    unit_cycles = 16'd2;
    send(2'b00);
    measure(1'b0, hi, gp, sp, rdy, dn, po1);
    chk("rt2 dot high", hi, 2);
    chk("rt2 dot gap", gp, 2);
    chk("rt2 done cycle", dn, 5);
    send(2'b00);
    unit_cycles = 16'd5;
    measure(1'b0, hi, gp, sp, rdy, dn, po1);
    chk("rt midchange high", hi, 2);
    chk("rt midchange done", dn, 5);
    send(2'b00);
    measure(1'b0, hi, gp, sp, rdy, dn, po1);
    chk("rt5 dot high", hi, 5);
    chk("rt5 dot gap", gp, 5);
    chk("rt5 done cycle", dn, 11);
    unit_cycles = 16'd0;
    send(2'b00);
    measure(1'b0, hi, gp, sp, rdy, dn, po1);
    chk("rt0 dot high", hi, 1);
    chk("rt0 done cycle", dn, 3);
    unit_cycles = 16'd4;
    repeat (3) @(negedge clk);
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
